fdd_data_separator: RTL and testbench
=====================================

Name: fdd_data_separator

Overview:
- Digital PLL data separator between the floppy drive read line (fd_rdat) and the WD1793-compatible controller inside the ULA.
- Recovers the read clock (vg_rclk) and a cleaned read-data strobe (vg_rawr_n) from raw MFM/FM flux pulses.
- Flags lock status for the magic/diagnostic menu.
- Runs entirely on clk28, upstream of the controller's read-data inputs.

Parameters:
- WIN_MFM, 56: clk28 cycles per data window in MFM (2 us).
- WIN_FM, 112: clk28 cycles per data window in FM (4 us).
- MAX_ADJ, 4: maximum window-length correction per window, in cycles.
- RAWR_LEN, 7: vg_rawr_n low-pulse width, in cycles (250 ns).
- LOCK_TOL, 6: maximum |phase error| for a pulse to count as in-lock.
- LOCK_CNT, 16: consecutive in-tolerance pulses required to assert locked.
- LOSS_WIN, 8: consecutive pulse-free windows that clear locked.

Ports:
- clk28, input, 1: system clock, 28 MHz.
- rst, input, 1: synchronous reset, active high.
- en, input, 1: drive selected and motor on; 0 freezes correction.
- mfm, input, 1: 1 = MFM window, 0 = FM window; sampled only at window wrap.
- fd_rdat, input, 1: raw drive read data, asynchronous, active-low pulses.
- vg_rclk, output, 1: recovered read clock; toggles at every window wrap.
- vg_rawr_n, output, 1: read-data strobe to the controller, active low.
- locked, output, 1: PLL lock indicator.

Behaviour:
- Reset, applied synchronously on rst=1 at any time including mid-pulse:
  - Outputs: vg_rclk=0, vg_rawr_n=1, locked=0.
  - Internal: cnt=0, term=WIN-1, lock_cnt=0, loss_cnt=0, synchroniser flops=1.
- Input path:
  - 2-FF synchroniser on fd_rdat, then falling-edge detect gives a one-cycle `pulse`.
  - Latency from fd_rdat falling to `pulse`: 3 clk28 edges.
- Window counter:
  - cnt increments each cycle.
  - When cnt==term: cnt<=0, vg_rclk toggles, term<=WIN-1 (WIN selected by mfm as sampled in that cycle), and the per-window `seen` flag clears.
- Phase correction, on the first `pulse` in a window with en=1:
  - err = cnt - WIN/2, signed 8-bit.
  - adj = err >>> 2 (arithmetic shift), clamped to [-MAX_ADJ, +MAX_ADJ].
  - term <= WIN-1+adj for the current window only.
  - Late pulse lengthens the window; early pulse shortens it.
  - err=0 leaves term unchanged.
- Pulse coincident with wrap (pulse and cnt==term in the same cycle): the wrap takes effect first; the pulse belongs to the new window with cnt=0 (err=-WIN/2, adj=-MAX_ADJ).
- Second and later pulses in the same window: no correction, no vg_rawr_n pulse, no effect on lock counters.
- RAWR strobe:
  - On an accepted pulse, vg_rawr_n goes low on the next cycle and stays low for exactly RAWR_LEN cycles.
  - A new accepted pulse during an active strobe does not retrigger or extend it.
- Lock tracking:
  - Accepted pulse with |err|<=LOCK_TOL: lock_cnt increments, saturating at LOCK_CNT. Reaching LOCK_CNT sets locked.
  - Accepted pulse with |err|>LOCK_TOL: lock_cnt<=0; locked is unchanged.
  - Each window wrap with no pulse in that window: loss_cnt increments. Reaching LOSS_WIN clears locked and lock_cnt.
  - Any accepted pulse: loss_cnt<=0.
- en=0:
  - Counter free-runs at nominal WIN; vg_rclk keeps toggling.
  - Pulses are ignored entirely; vg_rawr_n is held at 1.
  - locked=0; lock_cnt=0; loss_cnt=0.
- mfm change mid-window: takes effect at the next wrap only.

Decomposition:
- Package fdd_pkg holds:
  - WIN_MFM, WIN_FM.
  - Error and adjust widths (ERR_W=8).
  - Lock/loss counter widths.
  - A clamp function for adj.
- One sub-module: sync_fall, a 2-FF synchroniser plus falling-edge detector, reused later for the vg_wd path.

Test Plan:
- Reset: rst=1 for 3 cycles with fd_rdat toggling -> vg_rclk=0, vg_rawr_n=1, locked=0 throughout; first wrap at cycle 56 after release (mfm=1).
- Nominal MFM: en=1, pulses every 112 cycles centred at cnt=28 -> vg_rawr_n low for 7 cycles per pulse; vg_rclk period 112 cycles; locked rises on the 16th pulse.
- Late pulse: pulse at cnt=44 (err=+16) -> adj clamped to +4, that window wraps at cnt=59; the following window is back to 56 cycles.
- Early pulse and coincidence:
  - Pulse at cnt=20 (err=-8, adj=-2) -> window wraps at cnt=53.
  - Pulse landing exactly on wrap -> new-window err=-28, adj=-4.
- Loss and duplicates:
  - While locked, stop pulses for 8 windows -> locked drops at the 8th empty wrap.
  - Two pulses 10 cycles apart in one window -> only one vg_rawr_n strobe.
- en/mfm switching:
  - en=0 with pulses -> vg_rawr_n stays 1, locked=0.
  - mfm 1->0 mid-window -> current window ends at 56, the next lasts 112.

Source files
------------

// File: rtl/fdd_pkg.sv
// fdd_pkg: shared constants, types and helpers for the floppy read-data path.
//   win_len   : data-window length in clk28 cycles for the selected encoding
//   clamp_adj : phase error -> bounded window-length correction
package fdd_pkg;
  localparam int WIN_MFM  = 56;   // 2 us at 28 MHz
  localparam int WIN_FM   = 112;  // 4 us at 28 MHz
  localparam int RAWR_LEN = 7;    // 250 ns read-data strobe
  localparam int LOCK_TOL = 6;
  localparam int LOCK_CNT = 16;
  localparam int LOSS_WIN = 8;

  localparam int ERR_W  = 8;
  localparam int CNT_W  = 8;
  localparam int LOCK_W = $clog2(LOCK_CNT + 1);
  localparam int LOSS_W = $clog2(LOSS_WIN + 1);
  localparam int RAWR_W = $clog2(RAWR_LEN);

  typedef logic signed [ERR_W-1:0] err_t;
  typedef logic        [CNT_W-1:0] cnt_t;

  localparam err_t MAX_ADJ = err_t'(4);

  function automatic cnt_t win_len(input logic m);
    return m ? cnt_t'(WIN_MFM) : cnt_t'(WIN_FM);
  endfunction

  // Quarter of the phase error, bounded so one bad pulse cannot yank the loop.
  function automatic err_t clamp_adj(input err_t err);
    err_t a;
    a = err >>> 2;
    if (a > MAX_ADJ)  return MAX_ADJ;
    if (a < -MAX_ADJ) return -MAX_ADJ;
    return a;
  endfunction
endpackage

// File: rtl/sync_fall.sv
// sync_fall: 2-FF synchroniser plus registered falling-edge detector.
//   clk  : sampling clock
//   rst  : synchronous reset, active high (flops preset to idle-high)
//   din  : asynchronous active-low input
//   fall : one-cycle pulse, 3 clk edges after din falls
module sync_fall (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic fall
);
  // sh[1:0] synchronise, sh[2] is the previous synchronised value
  logic [2:0] sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh   <= 3'b111;
      fall <= 1'b0;
    end else begin
      sh   <= {sh[1:0], din};
      fall <= sh[2] & ~sh[1];
    end
  end
endmodule

// File: rtl/fdd_data_separator.sv
// fdd_data_separator: digital PLL data separator for the floppy read line.
//   clk28     : 28 MHz system clock
//   rst       : synchronous reset, active high
//   en        : drive selected and motor on; 0 freezes the loop
//   mfm       : 1 = MFM window, 0 = FM window (taken at window wrap)
//   fd_rdat   : raw drive read data, async, active-low pulses
//   vg_rclk   : recovered read clock, toggles on every window wrap
//   vg_rawr_n : cleaned read-data strobe, active low
//   locked    : loop lock indicator
module fdd_data_separator
  import fdd_pkg::*;
(
  input  logic clk28,
  input  logic rst,
  input  logic en,
  input  logic mfm,
  input  logic fd_rdat,
  output logic vg_rclk,
  output logic vg_rawr_n,
  output logic locked
);
  logic pulse;

  sync_fall u_sync (
    .clk  (clk28),
    .rst  (rst),
    .din  (fd_rdat),
    .fall (pulse)
  );

  cnt_t              cnt, term;
  logic              win_mfm;   // encoding of the window in progress
  logic              seen;      // a pulse was already accepted this window
  logic [LOCK_W-1:0] lock_cnt, lock_nx;
  logic [LOSS_W-1:0] loss_cnt, loss_nx;
  logic [RAWR_W-1:0] rawr_left;
  logic              locked_nx;

  logic wrap, accept, in_tol;
  cnt_t win_cur, pos, term_adj;
  err_t err, adj, abs_err;

  always_comb begin
    wrap    = (cnt == term);
    // A pulse coincident with the wrap belongs to the new window at cnt=0.
    win_cur = win_len(wrap ? mfm : win_mfm);
    pos     = wrap ? '0 : cnt;
    err     = err_t'(pos) - err_t'(win_cur >> 1);
    adj     = clamp_adj(err);
    term_adj = win_cur - cnt_t'(1) + cnt_t'(adj);
    abs_err = err[ERR_W-1] ? -err : err;
    in_tol  = (abs_err <= err_t'(LOCK_TOL));
    accept  = pulse & en & (wrap | ~seen);

    lock_nx   = lock_cnt;
    loss_nx   = loss_cnt;
    locked_nx = locked;
    if (!en) begin
      lock_nx   = '0;
      loss_nx   = '0;
      locked_nx = 1'b0;
    end else begin
      // Empty window is counted first; a pulse in the new window then resets it.
      if (wrap && !seen) begin
        if (loss_cnt >= LOSS_W'(LOSS_WIN - 1)) begin
          loss_nx   = LOSS_W'(LOSS_WIN);
          lock_nx   = '0;
          locked_nx = 1'b0;
        end else begin
          loss_nx = loss_cnt + LOSS_W'(1);
        end
      end
      if (accept) begin
        loss_nx = '0;
        if (in_tol) begin
          if (lock_nx != LOCK_W'(LOCK_CNT)) lock_nx = lock_nx + LOCK_W'(1);
          if (lock_nx == LOCK_W'(LOCK_CNT)) locked_nx = 1'b1;
        end else begin
          lock_nx = '0;
        end
      end
    end
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      cnt       <= '0;
      term      <= win_len(mfm) - cnt_t'(1);
      win_mfm   <= mfm;
      seen      <= 1'b0;
      vg_rclk   <= 1'b0;
      vg_rawr_n <= 1'b1;
      rawr_left <= '0;
      lock_cnt  <= '0;
      loss_cnt  <= '0;
      locked    <= 1'b0;
    end else begin
      if (wrap) begin
        cnt     <= '0;
        vg_rclk <= ~vg_rclk;
        win_mfm <= mfm;
      end else begin
        cnt <= cnt + cnt_t'(1);
      end

      // Correction applies to the current window only; wrap restores nominal.
      if (accept)    term <= term_adj;
      else if (wrap) term <= win_cur - cnt_t'(1);

      seen <= accept | (seen & ~wrap);

      // Strobe is fixed-width and never retriggered while low.
      if (!en) begin
        vg_rawr_n <= 1'b1;
        rawr_left <= '0;
      end else if (accept && vg_rawr_n) begin
        vg_rawr_n <= 1'b0;
        rawr_left <= RAWR_W'(RAWR_LEN - 1);
      end else if (rawr_left != '0) begin
        rawr_left <= rawr_left - RAWR_W'(1);
      end else begin
        vg_rawr_n <= 1'b1;
      end

      lock_cnt <= lock_nx;
      loss_cnt <= loss_nx;
      locked   <= locked_nx;
    end
  end
endmodule

// File: tb/tb_fdd_data_separator.sv
module tb_fdd_data_separator;
  logic clk28 = 1'b0, rst = 1'b1, en = 1'b1, mfm = 1'b1, fd_rdat = 1'b1;
  logic vg_rclk, vg_rawr_n, locked;

  fdd_data_separator dut (
    .clk28(clk28), .rst(rst), .en(en), .mfm(mfm), .fd_rdat(fd_rdat),
    .vg_rclk(vg_rclk), .vg_rawr_n(vg_rawr_n), .locked(locked)
  );

  always #5 clk28 = ~clk28;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // inputs as seen by the DUT at each rising edge
  logic c_rst = 1'b1, c_en = 1'b1, c_mfm = 1'b1, c_fd = 1'b1;
  always @(posedge clk28) begin
    c_rst <= rst; c_en <= en; c_mfm <= mfm; c_fd <= fd_rdat;
  end

  // behavioural model state
  int m_n = 0, m_pos = 0, m_len = 56, m_wmfm = 1, m_seen = 0, m_rclk = 0;
  int m_lock = 0, m_loss = 0, m_locked = 0, m_rawr_until = 0;
  int h1 = 1, h2 = 1, h3 = 1, h4 = 1;  // fd samples from 1..4 edges ago

  task automatic model_step(input logic r, input logic e, input logic mf, input logic fd);
    int ppos, w, err, adj, aerr;
    bit p, wrap;
    m_n++;
    p = (h4 == 1) && (h3 == 0);  // fd fell and made it through sync + detect
    h4 = h3; h3 = h2; h2 = h1; h1 = int'(fd);
    if (r) begin
      m_pos = 0; m_wmfm = int'(mf); m_len = mf ? 56 : 112; m_seen = 0; m_rclk = 0;
      m_lock = 0; m_loss = 0; m_locked = 0; m_rawr_until = 0;
      h1 = 1; h2 = 1; h3 = 1; h4 = 1;
      return;
    end
    wrap = (m_pos == m_len - 1);
    if (wrap) begin
      if (e && m_seen == 0) begin
        m_loss = (m_loss < 8) ? m_loss + 1 : 8;
        if (m_loss == 8) begin m_locked = 0; m_lock = 0; end
      end
      m_rclk = 1 - m_rclk; m_wmfm = int'(mf); m_len = mf ? 56 : 112;
      m_pos = 0; m_seen = 0; ppos = 0;
    end else begin
      ppos = m_pos; m_pos++;
    end
    w = (m_wmfm != 0) ? 56 : 112;
    if (p && e && m_seen == 0) begin
      err = ppos - w / 2;
      adj = (err >= 0) ? err / 4 : -((-err + 3) / 4);
      if (adj > 4) adj = 4;
      if (adj < -4) adj = -4;
      m_len = w + adj; m_seen = 1; m_loss = 0;
      aerr = (err < 0) ? -err : err;
      if (aerr <= 6) begin
        if (m_lock < 16) m_lock++;
        if (m_lock == 16) m_locked = 1;
      end else m_lock = 0;
      if (m_n - 1 >= m_rawr_until) m_rawr_until = m_n + 7;
    end
    if (!e) begin m_lock = 0; m_loss = 0; m_locked = 0; m_rawr_until = 0; end
  endtask

  // DUT-observed window lengths and strobe widths for directed checks
  int win_hist[$], rawr_hist[$];
  int last_tog = 0, run = 0;
  logic prev_rclk = 1'b0;

  initial begin
    forever begin
      @(negedge clk28);
      model_step(c_rst, c_en, c_mfm, c_fd);
      chk("vg_rclk", int'(vg_rclk), m_rclk);
      chk("vg_rawr_n", int'(vg_rawr_n), (m_n < m_rawr_until) ? 0 : 1);
      chk("locked", int'(locked), m_locked);
      if (vg_rclk !== prev_rclk) begin
        win_hist.push_back(m_n - last_tog); last_tog = m_n; prev_rclk = vg_rclk;
      end
      if (vg_rawr_n === 1'b0) run++;
      else if (run > 0) begin rawr_hist.push_back(run); run = 0; end
    end
  end

  task automatic tick();
    @(negedge clk28); #1;
  endtask

  task automatic sync_wrap();
    int k = 0;
    tick();
    while (m_pos != 0 && k < 300) begin tick(); k++; end
    chk("sync_wrap reached", int'(m_pos == 0), 1);
  endtask

  // fd low for one cycle so the core sees the pulse at cnt == c
  task automatic pulse_at(input int c);
    int k = 0;
    while (m_pos != c - 3 && k < 300) begin tick(); k++; end
    chk("pulse_at reached", int'(m_pos == c - 3), 1);
    fd_rdat = 1'b0; tick(); fd_rdat = 1'b1;
  endtask

  task automatic wait_hist(input int nw);
    int k = 0;
    while (win_hist.size() < nw && k < 400) begin tick(); k++; end
    chk("window history filled", int'(win_hist.size() >= nw), 1);
  endtask

  initial begin
    int k, lowleft, tgt, mode;
    bit fired;
    // reset with fd toggling
    for (int i = 0; i < 3; i++) begin
      fd_rdat = i[0];
      tick();
      chk("reset vg_rclk", int'(vg_rclk), 0);
      chk("reset vg_rawr_n", int'(vg_rawr_n), 1);
      chk("reset locked", int'(locked), 0);
    end
    fd_rdat = 1'b1; rst = 1'b0;
    k = 0;
    while (vg_rclk == 1'b0 && k < 200) begin tick(); k++; end
    chk("first wrap edge", k, 56);

    // nominal MFM, centred pulses every 112 cycles
    rawr_hist.delete();
    for (int i = 1; i <= 16; i++) begin
      pulse_at(28);
      repeat (5) tick();
      if (i == 15) chk("locked after 15 pulses", int'(locked), 0);
      if (i == 16) chk("locked after 16 pulses", int'(locked), 1);
      if (i < 16) begin sync_wrap(); sync_wrap(); end
    end
    chk("strobe width", rawr_hist[0], 7);
    chk("nominal window", win_hist[$], 56);

    // loss of lock after 8 empty windows
    for (int i = 1; i <= 9; i++) begin
      sync_wrap();
      if (i == 8) chk("locked after 7 empty", int'(locked), 1);
    end
    chk("locked after 8 empty", int'(locked), 0);

    // late pulse
    sync_wrap(); win_hist.delete();
    pulse_at(44); wait_hist(2);
    chk("late window", win_hist[0], 60);
    chk("window after late", win_hist[1], 56);

    // early pulse plus duplicate in the same window
    sync_wrap(); win_hist.delete(); rawr_hist.delete();
    pulse_at(20); pulse_at(30); wait_hist(1);
    chk("early window", win_hist[0], 54);
    chk("one strobe for duplicate", rawr_hist.size(), 1);

    // pulse coincident with wrap
    sync_wrap(); win_hist.delete();
    pulse_at(55); wait_hist(2);
    chk("window before coincidence", win_hist[0], 56);
    chk("window after coincidence", win_hist[1], 52);

    // en=0 ignores pulses
    en = 1'b0; rawr_hist.delete();
    repeat (3) begin sync_wrap(); pulse_at(28); end
    repeat (10) tick();
    chk("no strobe while disabled", rawr_hist.size(), 0);
    chk("locked while disabled", int'(locked), 0);

    // mfm change mid-window
    en = 1'b1; sync_wrap(); win_hist.delete();
    k = 0;
    while (m_pos != 20 && k < 200) begin tick(); k++; end
    mfm = 1'b0;
    wait_hist(2);
    chk("window at mfm switch", win_hist[0], 56);
    chk("first FM window", win_hist[1], 112);
    mfm = 1'b1; sync_wrap();

    // randomized: alternating free-running noise and jittered centred pulses
    lowleft = 0; tgt = 25; fired = 1'b0;
    for (int seg = 0; seg < 8; seg++) begin
      mode = seg % 2;
      for (int i = 0; i < 2000; i++) begin
        if (en) begin if ($urandom_range(0, 999) < 2) en = 1'b0; end
        else if ($urandom_range(0, 19) == 0) en = 1'b1;
        if ($urandom_range(0, 999) < 2) mfm = ~mfm;
        rst = ($urandom_range(0, 1999) == 0);
        if (m_pos == 0) begin
          tgt = ((m_wmfm != 0) ? 17 : 45) + $urandom_range(0, 16);
          fired = ($urandom_range(0, 7) == 0);
        end
        if (lowleft > 0) lowleft--;
        else if (mode == 0 ? ($urandom_range(0, 39) == 0) : (!fired && m_pos == tgt)) begin
          lowleft = $urandom_range(1, 3); fired = 1'b1;
        end
        fd_rdat = (lowleft == 0);
        tick();
      end
    end
    rst = 1'b0; fd_rdat = 1'b1;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
